centering_unit: RTL and testbench
=================================

Name: centering_unit

Overview:
- Mean-removal stage feeding the covariance unit inside whitening.
- Pass 1: accumulates NSAMP multi-channel samples streamed from mem1 and computes the per-channel mean with a shift.
- Pass 2: the same samples are re-streamed; the block subtracts the mean and emits centered samples toward mem2 and the covariance unit.
- Sequenced by the whitening controller through GO_cen; reports CEN_busy.

Parameters:
- NCH, 2, number of channels per sample.
- DATA_W, 24, signed two's-complement width of each channel sample in and out.
- NSAMP, 128, samples per pass; must be a power of two.
- LOG2_NSAMP, 7, log2(NSAMP).

Ports:
- CLK_cen  input  1  clock; all logic on rising edge.
- RST_cen  input  1  synchronous, active-high reset.
- GO_cen  input  1  level enable from the controller; held high for the whole operation; low aborts or clears.
- din_valid  input  1  din carries a sample this cycle.
- din  input  NCH*DATA_W  packed samples; channel k occupies bits [k*DATA_W +: DATA_W].
- dout_valid  output  1  dout carries a centered sample.
- dout  output  NCH*DATA_W  packed centered samples, same packing as din.
- mean  output  NCH*DATA_W  packed per-channel means; valid from the DIV cycle onward.
- CEN_busy  output  1  high while in SUM, DIV or SUB.
- cen_done  output  1  high while in DONE.

Behaviour:
- Reset when RST_cen=1 at a clock edge:
  - state=IDLE; accumulators, sample counter, mean, dout=0.
  - dout_valid=0, CEN_busy=0, cen_done=0.
- States: IDLE, SUM, DIV, SUB, DONE.
- IDLE: GO_cen=1 moves to SUM next cycle and clears the accumulators and counter. din is ignored in IDLE.
- SUM:
  - Each din_valid cycle: acc[k] += sign-extended din[k]. Accumulator width is DATA_W+LOG2_NSAMP, so it cannot overflow.
  - The counter increments per valid sample. The NSAMP-th valid sample is accumulated, then the state moves to DIV.
  - Cycles with din_valid=0 stall without changing state.
- DIV: exactly one cycle.
  - mean[k] = acc[k] >>> LOG2_NSAMP (arithmetic, floor), truncated to DATA_W bits. The result always fits in DATA_W.
  - Counter cleared; then SUB. din is ignored in DIV.
- SUB:
  - Each din_valid cycle: diff = din[k] - mean[k], computed in DATA_W+1 bits and saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - The result is registered, so dout/dout_valid appear 1 cycle after the din_valid cycle (latency 1).
  - After the NSAMP-th valid input the state moves to DONE. Its output emerges in the first DONE cycle.
  - dout holds its last value when dout_valid=0.
- DONE: cen_done=1, CEN_busy=0, mean held; GO_cen=0 returns to IDLE.
- GO_cen=0 in SUM, DIV or SUB aborts to IDLE next cycle:
  - accumulators and counter cleared; mean retained.
  - dout_valid=0 from the following cycle; a result already registered still emits once.
- RST_cen has priority over GO_cen and din_valid in every state.
- CEN_busy and cen_done are registered decodes of the state: they change in the same cycle the state changes.

Optional Feature:
- CEN_ROUND_EN defined: DIV computes mean = (acc + 2^(LOG2_NSAMP-1)) >>> LOG2_NSAMP, i.e. round-half-up. The adder is one bit wider to avoid overflow.
- CEN_ROUND_EN undefined: plain floor shift as above. Port list and timing are identical either way.

Test Plan:
- Constant input: ch0=1000, ch1=-1000 for 128 valid cycles, then the same stream again -> mean=(1000,-1000); 128 dout_valid pulses all (0,0); cen_done rises after the last output.
- Ramp: ch0=0..127 -> acc=8128. mean=63 floor, 64 with CEN_ROUND_EN. First dout = -63 (or -64); last dout = 64 (or 63).
- Saturation: DATA_W=24, SUM with 64 samples of 8388607 and 64 of -8388608 (mean=-1 floor), then SUB input 8388607 -> dout=8388607 (saturated; raw 8388608).
- Stalls: din_valid toggled 1-0-1 randomly in both passes -> exactly 128 samples counted per pass; each dout_valid 1 cycle after its din_valid; DIV still 1 cycle.
- Abort: drop GO_cen after 50 SUM samples -> IDLE next cycle, CEN_busy=0. Restart with GO_cen=1 -> fresh accumulation gives the correct mean with no residue.
- Reset priority: assert RST_cen mid-SUB while din_valid=1 -> all outputs 0 next cycle, state IDLE even with GO_cen held high; leaves IDLE at the next cycle after RST_cen drops.

Source files
------------

// File: rtl/centering_unit.sv
`default_nettype none
// ============================================================================
//  Module      : centering_unit
//  Description : Mean-removal stage in front of the whitening covariance unit.
//                Pass 1 accumulates NSAMP multi-channel samples and derives the
//                per-channel mean with an arithmetic shift.  Pass 2 re-streams
//                the same samples and emits (sample - mean), saturated to
//                DATA_W bits, with one cycle of latency.
//  Ports       : CLK_cen, RST_cen (sync, active high)  - clock / reset
//                GO_cen                                 - level enable, low aborts
//                din_valid, din[NCH*DATA_W]             - sample stream in
//                dout_valid, dout[NCH*DATA_W]           - centered stream out
//                mean[NCH*DATA_W]                       - per-channel means
//                CEN_busy, cen_done                     - status
//  Options     : CEN_ROUND_EN - when defined, the mean is rounded half-up
//                instead of floored.  Ports and timing are unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module centering_unit #(
    parameter int NCH        = 2,
    parameter int DATA_W     = 24,
    parameter int NSAMP      = 128,
    parameter int LOG2_NSAMP = 7
) (
    input  logic                  CLK_cen,
    input  logic                  RST_cen,
    input  logic                  GO_cen,
    input  logic                  din_valid,
    input  logic [NCH*DATA_W-1:0] din,
    output logic                  dout_valid,
    output logic [NCH*DATA_W-1:0] dout,
    output logic [NCH*DATA_W-1:0] mean,
    output logic                  CEN_busy,
    output logic                  cen_done
);

    // Accumulator is wide enough for NSAMP full-scale samples of either sign.
    localparam int ACC_W = DATA_W + LOG2_NSAMP;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SUM  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_SUB  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [LOG2_NSAMP-1:0] c_CNT_LAST = LOG2_NSAMP'(NSAMP - 1);
    localparam logic [LOG2_NSAMP-1:0] c_CNT_ONE  = LOG2_NSAMP'(1);

    logic [2:0]                  r_state;
    logic [LOG2_NSAMP-1:0]       r_cnt;
    logic signed [ACC_W-1:0]     r_acc [NCH];
    logic [NCH*DATA_W-1:0]       r_mean;
    logic [NCH*DATA_W-1:0]       r_dout;
    logic                        r_dout_valid;
    logic                        r_busy;
    logic                        r_done;

    logic signed [ACC_W-1:0]     w_acc_nxt [NCH];
    logic [NCH*DATA_W-1:0]       w_mean_div;
    logic [NCH*DATA_W-1:0]       w_diff_sat;
    logic                        w_last;

    assign w_last = (r_cnt == c_CNT_LAST);

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            logic signed [DATA_W-1:0] w_din_k;
            logic signed [DATA_W-1:0] w_mean_k;
            logic        [DATA_W:0]   w_diff;

            assign w_din_k  = din[k*DATA_W +: DATA_W];
            assign w_mean_k = r_mean[k*DATA_W +: DATA_W];

            assign w_acc_nxt[k] = r_acc[k] + {{LOG2_NSAMP{w_din_k[DATA_W-1]}}, w_din_k};

            // Only the DATA_W bits directly above the shift are kept, so the
            // shift kind does not matter for the retained bits.
`ifdef CEN_ROUND_EN
            // One extra bit so the rounding constant cannot wrap the sum.
            assign w_mean_div[k*DATA_W +: DATA_W] =
                DATA_W'(({r_acc[k][ACC_W-1], r_acc[k]} +
                         (ACC_W+1)'(1 << (LOG2_NSAMP - 1))) >> LOG2_NSAMP);
`else
            assign w_mean_div[k*DATA_W +: DATA_W] = DATA_W'(r_acc[k] >>> LOG2_NSAMP);
`endif

            // Difference in DATA_W+1 bits; the top two bits disagree exactly
            // when the result is outside the DATA_W range.
            assign w_diff = {w_din_k[DATA_W-1], w_din_k} - {w_mean_k[DATA_W-1], w_mean_k};

            assign w_diff_sat[k*DATA_W +: DATA_W] =
                (w_diff[DATA_W] != w_diff[DATA_W-1]) ?
                    (w_diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}}) :
                    w_diff[DATA_W-1:0];
        end
    endgenerate

    always_ff @(posedge CLK_cen) begin
        if (RST_cen) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            for (int k = 0; k < NCH; k++) r_acc[k] <= '0;
            r_mean       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // dout_valid is a single-cycle pulse per accepted SUB sample.
            r_dout_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (GO_cen) begin
                        r_state <= S_SUM;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        for (int k = 0; k < NCH; k++) r_acc[k] <= '0;
                    end
                end
                S_SUM, S_DIV, S_SUB: begin
                    if (!GO_cen) begin
                        // Abort: mean is intentionally kept.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        for (int k = 0; k < NCH; k++) r_acc[k] <= '0;
                    end else if (r_state == S_SUM) begin
                        if (din_valid) begin
                            for (int k = 0; k < NCH; k++) r_acc[k] <= w_acc_nxt[k];
                            r_cnt <= r_cnt + c_CNT_ONE;
                            if (w_last) r_state <= S_DIV;
                        end
                    end else if (r_state == S_DIV) begin
                        r_mean  <= w_mean_div;
                        r_cnt   <= '0;
                        r_state <= S_SUB;
                    end else if (din_valid) begin
                        r_dout       <= w_diff_sat;
                        r_dout_valid <= 1'b1;
                        r_cnt        <= r_cnt + c_CNT_ONE;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!GO_cen) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign mean       = r_mean;
    assign CEN_busy   = r_busy;
    assign cen_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_centering_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_centering_unit
//  Description : Directed self-checking bench for centering_unit (NCH=2,
//                DATA_W=24, NSAMP=128).  Expected values are hand-derived;
//                CEN_ROUND_EN selects the rounded-mean expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_centering_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        din_valid;
    logic [47:0] din;
    logic        dout_valid;
    logic [47:0] dout;
    logic [47:0] mean;
    logic        busy;
    logic        done;

    centering_unit #(
        .NCH(2), .DATA_W(24), .NSAMP(128), .LOG2_NSAMP(7)
    ) dut (
        .CLK_cen   (clk),
        .RST_cen   (rst),
        .GO_cen    (go),
        .din_valid (din_valid),
        .din       (din),
        .dout_valid(dout_valid),
        .dout      (dout),
        .mean      (mean),
        .CEN_busy  (busy),
        .cen_done  (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int p1c0 [128];
    int p1c1 [128];
    int p2c0 [128];
    int p2c1 [128];
    longint q0 [$];
    longint q1 [$];
    bit  sub_phase = 1'b0;
    bit  mon_en    = 1'b0;
    int  lat_err   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [23:0] v);
        return longint'($signed(v));
    endfunction

    // Advance one clock; capture outputs 1 time unit after the edge.
    task automatic tick;
        bit expect_dv;
        expect_dv = sub_phase && din_valid;
        @(posedge clk);
        #1;
        if (dout_valid) begin
            q0.push_back(sx(dout[23:0]));
            q1.push_back(sx(dout[47:24]));
        end
        if (mon_en && (dout_valid !== expect_dv)) lat_err++;
    endtask

    task automatic stream(input bit pass2, input bit stall);
        int a, b;
        sub_phase = pass2;
        mon_en    = pass2;
        for (int i = 0; i < 128; i++) begin
            if (stall) begin
                repeat ($urandom_range(0, 2)) begin
                    din_valid = 1'b0;
                    tick();
                end
            end
            a = pass2 ? p2c0[i] : p1c0[i];
            b = pass2 ? p2c1[i] : p1c1[i];
            din       = {b[23:0], a[23:0]};
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        sub_phase = 1'b0;
    endtask

    task automatic run(input string tag, input bit stall);
        q0.delete();
        q1.delete();
        lat_err = 0;
        go = 1'b1;
        tick();
        check({tag, "_busy_sum"}, longint'(busy), 1);
        stream(1'b0, stall);
        check({tag, "_busy_div"}, longint'(busy), 1);
        tick();                         // DIV -> SUB
        stream(1'b1, stall);
        mon_en = 1'b0;
        check({tag, "_done"}, longint'(done), 1);
        check({tag, "_busy_done"}, longint'(busy), 0);
        check({tag, "_nout"}, longint'(q0.size()), 128);
        check({tag, "_latency"}, longint'(lat_err), 0);
    endtask

    task automatic finish_run(input string tag);
        go = 1'b0;
        tick();
        check({tag, "_done_clr"}, longint'(done), 0);
    endtask

    initial begin
        int nz;
        longint m0_sat;
        rst = 1'b1; go = 1'b0; din_valid = 1'b0; din = '0;
        tick(); tick();
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_dv", longint'(dout_valid), 0);
        check("rst_dout", longint'(dout), 0);
        check("rst_mean", longint'(mean), 0);
        rst = 1'b0;
        tick();
        check("idle_busy", longint'(busy), 0);

        // Constant input
        for (int i = 0; i < 128; i++) begin
            p1c0[i] = 1000; p1c1[i] = -1000; p2c0[i] = 1000; p2c1[i] = -1000;
        end
        run("const", 1'b0);
        check("const_mean0", sx(mean[23:0]), 1000);
        check("const_mean1", sx(mean[47:24]), -1000);
        nz = 0;
        foreach (q0[i]) if (q0[i] != 0 || q1[i] != 0) nz++;
        check("const_nonzero", longint'(nz), 0);
        finish_run("const");

        // Ramp with random stalls in both passes
        for (int i = 0; i < 128; i++) begin
            p1c0[i] = i; p1c1[i] = -i; p2c0[i] = i; p2c1[i] = -i;
        end
        run("ramp", 1'b1);
`ifdef CEN_ROUND_EN
        check("ramp_mean0", sx(mean[23:0]), 64);
        check("ramp_mean1", sx(mean[47:24]), -63);
        check("ramp_first0", q0[0], -64);
        check("ramp_last0", q0[127], 63);
        check("ramp_first1", q1[0], 63);
        check("ramp_last1", q1[127], -64);
`else
        check("ramp_mean0", sx(mean[23:0]), 63);
        check("ramp_mean1", sx(mean[47:24]), -64);
        check("ramp_first0", q0[0], -63);
        check("ramp_last0", q0[127], 64);
        check("ramp_first1", q1[0], 64);
        check("ramp_last1", q1[127], -63);
`endif
        finish_run("ramp");

        // Saturation in both directions
        for (int i = 0; i < 128; i++) begin
            p1c0[i] = (i < 64) ? 8388607 : -8388608;
            p1c1[i] = 8388607;
            p2c0[i] = 8388607;
            p2c1[i] = -8388608;
        end
        run("sat", 1'b0);
`ifdef CEN_ROUND_EN
        m0_sat = 0;
`else
        m0_sat = -1;
`endif
        check("sat_mean0", sx(mean[23:0]), m0_sat);
        check("sat_mean1", sx(mean[47:24]), 8388607);
        check("sat_pos", q0[127], 8388607);
        check("sat_neg", q1[127], -8388608);
        finish_run("sat");

        // Abort after 50 SUM samples, then a fresh run
        go = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) begin
            din = {24'd7777, 24'd5000};
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        go = 1'b0;
        tick();
        check("abort_busy", longint'(busy), 0);
        check("abort_mean_kept", sx(mean[23:0]), m0_sat);
        tick();
        for (int i = 0; i < 128; i++) begin
            p1c0[i] = 1000; p1c1[i] = -1000; p2c0[i] = 1000; p2c1[i] = -1000;
        end
        run("restart", 1'b0);
        check("restart_mean0", sx(mean[23:0]), 1000);
        check("restart_mean1", sx(mean[47:24]), -1000);
        finish_run("restart");

        // Reset priority mid-SUB
        for (int i = 0; i < 128; i++) begin
            p2c0[i] = 1234; p2c1[i] = 0;
        end
        go = 1'b1;
        tick();
        stream(1'b0, 1'b0);
        tick();
        mon_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din = {24'd0, 24'd1234};
            din_valid = 1'b1;
            tick();
        end
        check("pre_rst_dout0", sx(dout[23:0]), 234);
        check("pre_rst_dout1", sx(dout[47:24]), 1000);
        rst = 1'b1;
        tick();
        check("rstp_dout", longint'(dout), 0);
        check("rstp_dv", longint'(dout_valid), 0);
        check("rstp_busy", longint'(busy), 0);
        check("rstp_mean", longint'(mean), 0);
        tick();
        check("rstp_hold_busy", longint'(busy), 0);
        rst = 1'b0;
        din_valid = 1'b0;
        tick();
        check("rstp_leave_idle", longint'(busy), 1);
        go = 1'b0;
        tick();
        check("final_busy", longint'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
